// File: rtl/wb_collect_pkg.sv
// wb_collect_pkg: shared load-type codes for the writeback collector and its
// load extraction helper.
//   ltype_t  : 3-bit load type code driven by MEM alongside a load
//   LTYPE_W  : width of the load type field
package wb_collect_pkg;

  localparam int unsigned LTYPE_W = 3;

  typedef enum logic [LTYPE_W-1:0] {
    LT_W  = 3'd0,
    LT_H  = 3'd1,
    LT_HU = 3'd2,
    LT_B  = 3'd3,
    LT_BU = 3'd4,
    LT_D  = 3'd5
  } ltype_t;

endpackage

// File: rtl/wb_collect_extract.sv
// load_extract: combinational little-endian sub-word selection and extension
// of a raw aligned read word.
//   rdata   : raw aligned read word from memory
//   ltype   : load type code (LT_*); unknown codes behave as LT_W
//   offs    : byte address low bits; misaligned low bits are ignored
//   value_c : extracted, sign-/zero-extended result
module load_extract
  import wb_collect_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned OFFS_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0]  rdata,
  input  logic [LTYPE_W-1:0] ltype,
  input  logic [OFFS_W-1:0]  offs,
  output logic [DATA_W-1:0]  value_c
);

  logic [OFFS_W-1:0] offs_h;
  logic [OFFS_W-1:0] offs_w;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       word_v;

  // Halfword and word lanes drop the offset bits below their natural alignment.
  assign offs_h = offs & ~OFFS_W'(1);
  assign offs_w = offs & ~OFFS_W'(3);

  assign byte_v = 8'(rdata >> {offs, 3'b000});
  assign half_v = 16'(rdata >> {offs_h, 3'b000});
  assign word_v = 32'(rdata >> {offs_w, 3'b000});

  // Extension by load type; LT_W is the fallback for unlisted codes.
  always_comb begin
    value_c = DATA_W'($signed(word_v));
    case (ltype)
      LT_B:    value_c = DATA_W'($signed(byte_v));
      LT_BU:   value_c = DATA_W'(byte_v);
      LT_H:    value_c = DATA_W'($signed(half_v));
      LT_HU:   value_c = DATA_W'(half_v);
      LT_D:    value_c = rdata;
      default: value_c = DATA_W'($signed(word_v));
    endcase
  end

endmodule

// File: rtl/wb_collect.sv
// wb_collect: in-order writeback collector. Queues instructions from MEM,
// waits for in-order load data, extracts sub-word load values and retires one
// entry per cycle as a registered register-file write.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : MEM handshake (in_ready depends on count only)
//   in_regf, in_data      : destination register (0 = no write), non-load result
//   in_load, in_ltype,
//   in_offs               : load flag, load type, byte offset
//   mem_rvalid, mem_rdata : in-order read data return
//   rd_we, rd_regf,
//   rd_data               : registered register-file write port
//   hz_regf, hz_hit       : ID hazard query against queued entries (comb)
//   err                   : sticky, read data arrived with no outstanding load
module wb_collect
  import wb_collect_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned REGF_W = 5,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned OFFS_W = $clog2(DATA_W / 8)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REGF_W-1:0]   in_regf,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_load,
  input  logic [LTYPE_W-1:0]  in_ltype,
  input  logic [OFFS_W-1:0]   in_offs,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rd_we,
  output logic [REGF_W-1:0]   rd_regf,
  output logic [DATA_W-1:0]   rd_data,
  input  logic [REGF_W-1:0]   hz_regf,
  output logic                hz_hit,
  output logic                err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [REGF_W-1:0]  regf;
    logic [DATA_W-1:0]  data;
    logic               load;
    logic [LTYPE_W-1:0] ltype;
    logic [OFFS_W-1:0]  offs;
    logic               done;
  } entry_t;

  entry_t             q [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic               accept;
  logic               retire;
  logic               cmp_found;
  logic [PTR_W-1:0]   cmp_idx;
  logic [DATA_W-1:0]  ext_value;

  assign in_ready = (count < CNT_W'(DEPTH));
  assign accept   = in_valid & in_ready;
  assign retire   = (count != '0) & q[head].done;

  // Oldest queued load still waiting for data, scanning from the head.
  always_comb begin
    cmp_found = 1'b0;
    cmp_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!cmp_found && (CNT_W'(i) < count) &&
          q[head + PTR_W'(i)].load && !q[head + PTR_W'(i)].done) begin
        cmp_found = 1'b1;
        cmp_idx   = head + PTR_W'(i);
      end
    end
  end

  // Hazard query over live entries; the rd_* register is not included since
  // the register file writes through.
  always_comb begin
    hz_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (q[head + PTR_W'(i)].regf == hz_regf)) begin
        hz_hit = 1'b1;
      end
    end
    if (hz_regf == '0) begin
      hz_hit = 1'b0;
    end
  end

  load_extract #(
    .DATA_W (DATA_W)
  ) u_extract (
    .rdata   (mem_rdata),
    .ltype   (q[cmp_idx].ltype),
    .offs    (q[cmp_idx].offs),
    .value_c (ext_value)
  );

  // Queue storage: accept at tail, complete loads in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      if (accept) begin
        q[tail].regf  <= in_regf;
        q[tail].data  <= in_data;
        q[tail].load  <= in_load;
        q[tail].ltype <= in_ltype;
        q[tail].offs  <= in_offs;
        q[tail].done  <= ~in_load;
      end
      // Never collides with the accept slot: tail is free whenever accept fires.
      if (mem_rvalid && cmp_found) begin
        q[cmp_idx].data <= ext_value;
        q[cmp_idx].done <= 1'b1;
      end
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) begin
        tail <= tail + PTR_W'(1);
      end
      if (retire) begin
        head <= head + PTR_W'(1);
      end
      case ({accept, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered register-file write; index and data hold when nothing retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_we   <= 1'b0;
      rd_regf <= '0;
      rd_data <= '0;
    end else if (retire) begin
      rd_we   <= (q[head].regf != '0);
      rd_regf <= q[head].regf;
      rd_data <= q[head].data;
    end else begin
      rd_we   <= 1'b0;
    end
  end

  // Sticky error for read data with no outstanding load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (mem_rvalid && !cmp_found) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_collect.sv
// tb_wb_collect: directed self-checking bench for wb_collect (DATA_W=32,
// REGF_W=5, DEPTH=4). Inputs change #1 after each rising edge; outputs are
// sampled at the same point, away from the edge.
module tb_wb_collect;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_regf;
  logic [31:0] in_data;
  logic        in_load;
  logic [2:0]  in_ltype;
  logic [1:0]  in_offs;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rd_we;
  logic [4:0]  rd_regf;
  logic [31:0] rd_data;
  logic [4:0]  hz_regf;
  logic        hz_hit;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  wb_collect #(
    .DATA_W (32),
    .REGF_W (5),
    .DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_regf    (in_regf),
    .in_data    (in_data),
    .in_load    (in_load),
    .in_ltype   (in_ltype),
    .in_offs    (in_offs),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rd_we      (rd_we),
    .rd_regf    (rd_regf),
    .rd_data    (rd_data),
    .hz_regf    (hz_regf),
    .hz_hit     (hz_hit),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid   = 1'b0;
    in_regf    = '0;
    in_data    = '0;
    in_load    = 1'b0;
    in_ltype   = 3'd0;
    in_offs    = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic push(input logic [4:0] regf, input logic [31:0] data,
                      input logic load, input logic [2:0] lt, input logic [1:0] offs);
    idle_in();
    in_valid = 1'b1;
    in_regf  = regf;
    in_data  = data;
    in_load  = load;
    in_ltype = lt;
    in_offs  = offs;
  endtask

  task automatic rvalid(input logic [31:0] data);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] regf, input logic [31:0] data);
    chk({tag, ".we"},   32'(rd_we),   32'd1);
    chk({tag, ".regf"}, 32'(rd_regf), 32'(regf));
    chk({tag, ".data"}, rd_data,      data);
  endtask

  initial begin
    rst_n   = 1'b0;
    hz_regf = 5'd5;
    idle_in();
    repeat (2) tick();

    // Reset state
    chk("rst.rd_we",    32'(rd_we),    32'd0);
    chk("rst.rd_regf",  32'(rd_regf),  32'd0);
    chk("rst.rd_data",  rd_data,       32'd0);
    chk("rst.err",      32'(err),      32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.hz_hit",   32'(hz_hit),   32'd0);
    rst_n = 1'b1;

    // Non-load: accepted cycle 0, written in cycle 2 only
    tick(); push(5'd5, 32'h1234, 1'b0, 3'd0, 2'd0);
    tick(); idle_in(); #1;
    chk("alu.c1.we", 32'(rd_we),  32'd0);
    chk("alu.c1.hz", 32'(hz_hit), 32'd1);
    tick();
    chk_wr("alu.c2", 5'd5, 32'h1234);
    chk("alu.c2.hz", 32'(hz_hit), 32'd0);
    tick();
    chk("alu.c3.we",   32'(rd_we),   32'd0);
    chk("alu.c3.regf", 32'(rd_regf), 32'd5);
    chk("alu.c3.data", rd_data,      32'h1234);

    // LT_B offs=1, rvalid three cycles later
    tick(); push(5'd7, 32'h0, 1'b1, 3'd3, 2'd1);
    tick(); idle_in();
    tick();
    tick(); rvalid(32'h0000_8000);
    tick(); idle_in();
    chk("lb.k1.we", 32'(rd_we), 32'd0);
    tick();
    chk_wr("lb.k2", 5'd7, 32'hFFFF_FF80);

    // LT_BU offs=1
    tick(); push(5'd7, 32'h0, 1'b1, 3'd4, 2'd1);
    tick(); idle_in(); rvalid(32'h0000_8000);
    tick(); idle_in();
    chk("lbu.k1.we", 32'(rd_we), 32'd0);
    tick();
    chk_wr("lbu.k2", 5'd7, 32'h0000_0080);

    // Two halfword loads, data returned back to back
    tick(); push(5'd8, 32'h0, 1'b1, 3'd2, 2'd2);
    tick(); push(5'd9, 32'h0, 1'b1, 3'd1, 2'd0);
    tick(); idle_in(); rvalid(32'hABCD_8765);
    tick(); rvalid(32'h0000_F00F);
    tick(); idle_in();
    chk_wr("lhu.r8", 5'd8, 32'h0000_ABCD);
    tick();
    chk_wr("lh.r9", 5'd9, 32'hFFFF_F00F);

    // Pending load r3 blocks non-loads r4, r5
    tick(); push(5'd3, 32'h0, 1'b1, 3'd0, 2'd0);
    tick(); push(5'd4, 32'h44, 1'b0, 3'd0, 2'd0);
    tick(); push(5'd5, 32'h55, 1'b0, 3'd0, 2'd0);
    tick(); idle_in(); hz_regf = 5'd4; #1;
    chk("ord.c3.hz", 32'(hz_hit), 32'd1);
    tick();
    chk("ord.c4.we", 32'(rd_we),  32'd0);
    tick(); rvalid(32'hCAFE_F00D);
    tick(); idle_in();
    chk("ord.c6.we", 32'(rd_we),  32'd0);
    chk("ord.c6.hz", 32'(hz_hit), 32'd1);
    tick();
    chk_wr("ord.r3", 5'd3, 32'hCAFE_F00D);
    chk("ord.c7.hz", 32'(hz_hit), 32'd1);
    tick();
    chk_wr("ord.r4", 5'd4, 32'h44);
    chk("ord.c8.hz", 32'(hz_hit), 32'd0);
    tick();
    chk_wr("ord.r5", 5'd5, 32'h55);
    hz_regf = 5'd0;

    // Fill with DEPTH loads, then drain; includes an r0 entry
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full.rdy_pre", 32'(in_ready), 32'd1);
      push(5'(10 + i), 32'h0, 1'b1, 3'd0, 2'd0);
    end
    tick(); idle_in(); rvalid(32'h1);
    chk("full.c4.rdy", 32'(in_ready), 32'd0);
    tick(); idle_in();
    chk("full.c5.rdy", 32'(in_ready), 32'd0);
    tick();
    chk("full.c6.rdy", 32'(in_ready), 32'd1);
    chk_wr("full.r10", 5'd10, 32'h1);
    push(5'd0, 32'h99, 1'b0, 3'd0, 2'd0); rvalid(32'h2);
    tick(); idle_in(); rvalid(32'h3);
    tick(); rvalid(32'h4);
    chk_wr("full.r11", 5'd11, 32'h2);
    tick(); idle_in();
    chk_wr("full.r12", 5'd12, 32'h3);
    tick();
    chk_wr("full.r13", 5'd13, 32'h4);
    tick();
    chk("r0.we",   32'(rd_we),   32'd0);
    chk("r0.regf", 32'(rd_regf), 32'd0);
    chk("r0.data", rd_data,      32'h99);
    chk("r0.err",  32'(err),     32'd0);

    // Stray read data on an empty queue
    tick(); rvalid(32'hDEAD);
    tick(); idle_in();
    chk("err.set", 32'(err),   32'd1);
    chk("err.we",  32'(rd_we), 32'd0);
    tick();
    chk("err.sticky", 32'(err), 32'd1);

    // Reset with two loads queued
    tick(); push(5'd20, 32'h0, 1'b1, 3'd0, 2'd0);
    tick(); push(5'd21, 32'h0, 1'b1, 3'd0, 2'd0);
    tick(); idle_in(); hz_regf = 5'd20; #1;
    chk("pre_rst.hz",  32'(hz_hit),   32'd1);
    chk("pre_rst.rdy", 32'(in_ready), 32'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst.we",  32'(rd_we),    32'd0);
    chk("mid_rst.err", 32'(err),      32'd0);
    chk("mid_rst.rdy", 32'(in_ready), 32'd1);
    chk("mid_rst.hz",  32'(hz_hit),   32'd0);
    tick(); tick();
    rst_n = 1'b1;
    // Queue was discarded, so returning data has no load to complete
    tick(); rvalid(32'h5);
    tick(); idle_in();
    chk("post_rst.err", 32'(err),   32'd1);
    chk("post_rst.we",  32'(rd_we), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
